cond_unit_pipe: RTL
===================

Name: cond_unit_pipe

Overview:
- Execute-stage condition and flag unit for the pipelined ARM core; the consuming end of the ALU's NZCV flag interface.
- Holds the architectural NZCV register and evaluates each instruction's 4-bit condition field against it.
- Annuls register, memory and PC writes of instructions whose condition fails.
- Supplies the registered C flag back to the ALU carry input, and keeps a one-deep shadow copy of the flags for save/restore around exceptions.

Parameters:
- RESET_FLAGS, 4'b0000: NZCV value loaded on reset.
- PERF_W, 32: width of the performance counters; used only with COND_PERF_CNT_EN.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- ValidE  in  1  instruction present in Execute
- StallE  in  1  Execute held this cycle
- FlushE  in  1  Execute instruction is squashed
- CondE  in  4  ARM condition field
- FlagWriteE  in  2  [1] updates N,Z; [0] updates C,V
- ALUFlags  in  4  {N,Z,C,V} from the ALU this cycle
- RegWriteE, MemWriteE, PCSrcE  in  1 each  ungated control
- FlagSave  in  1  copy flags to shadow
- FlagRestore  in  1  copy shadow to flags
- RegWriteGE, MemWriteGE, PCSrcGE  out  1 each  gated control
- CondExE  out  1  condition passed
- Flags  out  4  architectural {N,Z,C,V}
- CarryFlag  out  1  Flags[1], to ALU carry input
- SavedFlags  out  4  shadow register

Behaviour:
- Reset (sync, active-high):
  - Flags <= RESET_FLAGS; SavedFlags <= RESET_FLAGS.
  - Performance counters <= 0.
  - All gated outputs are combinational and therefore low whenever ValidE=0.
- Fire condition: fire = ValidE & ~StallE & ~FlushE.
- Condition evaluation:
  - CondExE is a combinational function of CondE and the current Flags register. It does not depend on ALUFlags, so there is no same-cycle loop.
  - EQ Z, NE ~Z, CS C, CC ~C, MI N, PL ~N, VS V, VC ~V.
  - HI C&~Z, LS ~C|Z, GE N==V, LT N!=V, GT ~Z&(N==V), LE Z|(N!=V).
  - AL=1110 and 1111 both pass.
- Gating: XWriteGE = XWriteE & CondExE & ValidE & ~FlushE. Gated outputs are independent of StallE; downstream registers honour the stall.
- Flag update:
  - Happens on the rising edge when fire & CondExE.
  - If FlagWriteE[1]: N,Z <= ALUFlags[3:2].
  - If FlagWriteE[0]: C,V <= ALUFlags[1:0].
  - Latency: the updated flags are visible to CondExE and CarryFlag the next cycle. Back-to-back dependent instructions therefore need no forwarding.
- Failed condition: the flags and all gated writes are untouched.
- Save/restore (independent of ValidE):
  - FlagSave: SavedFlags <= Flags. The value saved is the pre-update value, even when a flag write fires in the same cycle.
  - FlagRestore: Flags <= SavedFlags.
- Priority on Flags: reset > FlagRestore > fired flag write. A restore in the same cycle as a flag write discards the write.
- FlagSave and FlagRestore in the same cycle: the old values swap; Flags gets old SavedFlags and SavedFlags gets old Flags.
- Stall: while StallE=1 nothing updates except save/restore. A held instruction evaluates against unchanged flags each cycle.
- Flush: with FlushE=1 there are no flag updates and no gated writes, even if the condition passes.
- Reset mid-stall: Flags return to RESET_FLAGS and any in-flight update is dropped.

Optional Feature:
- Macro: COND_PERF_CNT_EN.
- When defined, two PERF_W-bit counters are added, with outputs ExecCount and AnnulCount:
  - ExecCount increments on fire & CondExE.
  - AnnulCount increments on fire & ~CondExE.
  - Both counters wrap modulo 2^PERF_W.
  - Both read 0 after reset.
- When undefined, the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package cond_pkg:
  - cond_e enum (EQ..AL, NV=4'b1111).
  - Flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - flags_t typedef (logic [3:0]).
- One combinational sub-module cond_eval (inputs cond_e and flags_t, output pass); it is reused by the Decode-stage branch predictor.
- The registers and gating stay in cond_unit_pipe.

Test Plan:
1. Reset, then CondE=EQ, ValidE=1, RegWriteE=1 -> CondExE=0, RegWriteGE=0. Cycle 2: ALUFlags=0100, FlagWriteE=11, CondE=AL -> next cycle Flags=0100 and the EQ instruction gives RegWriteGE=1.
2. Flags=1001 (N=1,V=1): CondE=GE -> pass; LT -> fail; GT -> pass; set Z (Flags=1101) and GT -> fail, LE -> pass. Sweep all 16 codes over all 16 flag values against a model.
3. FlagWriteE=10 with ALUFlags=1111 from Flags=0000 -> Flags=1100 (C,V unchanged); then FlagWriteE=01 with ALUFlags=0010 -> Flags=1110; CarryFlag=1.
4. StallE=1 for 3 cycles with FlagWriteE=11, ALUFlags=0110 -> Flags unchanged until the cycle StallE drops, then 0110. FlushE=1 with MemWriteE=1 and CondE=AL -> MemWriteGE=0, Flags unchanged.
5. Flags=1010; FlagSave; then a write sets 0101; FlagRestore together with a fired write of 1111 -> Flags=1010. Save and restore together with Flags=0001, SavedFlags=1000 -> swap to 1000/0001.
6. With COND_PERF_CNT_EN: 5 passing and 3 failing fired instructions plus 2 stalled ones -> ExecCount=5, AnnulCount=3. With PERF_W=4, 17 passes -> ExecCount=1.

Source files
------------

// File: rtl/cond_pkg.sv
// Shared condition-code types for the Execute condition unit and Decode branch predictor.
// Pure type/constant package; no latency or backpressure of its own.
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
    MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
    HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
    GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [3:0] flags_t;

endpackage

// File: rtl/cond_unit_pipe_if.sv
// Execute-stage control bundle between the pipeline (master) and the condition unit (slave).
// Perf-counter outputs exist only when COND_PERF_CNT_EN is defined.
interface cond_unit_pipe_if #(parameter int PERF_W = 32);
  import cond_pkg::*;

  logic       ValidE;
  logic       StallE;
  logic       FlushE;
  logic [3:0] CondE;
  logic [1:0] FlagWriteE;
  flags_t     ALUFlags;
  logic       RegWriteE;
  logic       MemWriteE;
  logic       PCSrcE;
  logic       FlagSave;
  logic       FlagRestore;
  logic       RegWriteGE;
  logic       MemWriteGE;
  logic       PCSrcGE;
  logic       CondExE;
  flags_t     Flags;
  logic       CarryFlag;
  flags_t     SavedFlags;
`ifdef COND_PERF_CNT_EN
  logic [PERF_W-1:0] ExecCount;
  logic [PERF_W-1:0] AnnulCount;

  modport master (
    output ValidE, StallE, FlushE, CondE, FlagWriteE, ALUFlags,
           RegWriteE, MemWriteE, PCSrcE, FlagSave, FlagRestore,
    input  RegWriteGE, MemWriteGE, PCSrcGE, CondExE, Flags, CarryFlag,
           SavedFlags, ExecCount, AnnulCount
  );
  modport slave (
    input  ValidE, StallE, FlushE, CondE, FlagWriteE, ALUFlags,
           RegWriteE, MemWriteE, PCSrcE, FlagSave, FlagRestore,
    output RegWriteGE, MemWriteGE, PCSrcGE, CondExE, Flags, CarryFlag,
           SavedFlags, ExecCount, AnnulCount
  );
`else
  modport master (
    output ValidE, StallE, FlushE, CondE, FlagWriteE, ALUFlags,
           RegWriteE, MemWriteE, PCSrcE, FlagSave, FlagRestore,
    input  RegWriteGE, MemWriteGE, PCSrcGE, CondExE, Flags, CarryFlag,
           SavedFlags
  );
  modport slave (
    input  ValidE, StallE, FlushE, CondE, FlagWriteE, ALUFlags,
           RegWriteE, MemWriteE, PCSrcE, FlagSave, FlagRestore,
    output RegWriteGE, MemWriteGE, PCSrcGE, CondExE, Flags, CarryFlag,
           SavedFlags
  );
`endif

endinterface

// File: rtl/cond_eval.sv
// ARM condition-field evaluator against an NZCV value; purely combinational.
// No state, no backpressure.
module cond_eval
  import cond_pkg::*;
(
  input  cond_e  cond,
  input  flags_t flags,
  output logic   pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    unique case (cond)
      EQ: pass = z;
      NE: pass = ~z;
      CS: pass = c;
      CC: pass = ~c;
      MI: pass = n;
      PL: pass = ~n;
      VS: pass = v;
      VC: pass = ~v;
      HI: pass = c & ~z;
      LS: pass = ~c | z;
      GE: pass = (n == v);
      LT: pass = (n != v);
      GT: pass = ~z & (n == v);
      LE: pass = z | (n != v);
      AL: pass = 1'b1;
      NV: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit_pipe.sv
// Execute NZCV register, condition check and write gating; flags update visible next cycle.
// No backpressure: StallE only blocks state updates; COND_PERF_CNT_EN adds exec/annul counters.
module cond_unit_pipe
  import cond_pkg::*;
#(
  parameter flags_t RESET_FLAGS = 4'b0000,
  parameter int     PERF_W      = 32
) (
  input logic         clk,
  input logic         reset,
  cond_unit_pipe_if.slave bus
);

  flags_t flags_q;
  flags_t saved_q;
  logic   cond_pass;
  logic   fire;
  logic   live;

  cond_eval u_eval (
    .cond  (cond_e'(bus.CondE)),
    .flags (flags_q),
    .pass  (cond_pass)
  );

  assign fire = bus.ValidE & ~bus.StallE & ~bus.FlushE;
  // Gated writes ignore the stall; downstream pipeline registers hold on StallE themselves.
  assign live = cond_pass & bus.ValidE & ~bus.FlushE;

  assign bus.CondExE    = cond_pass;
  assign bus.RegWriteGE = bus.RegWriteE & live;
  assign bus.MemWriteGE = bus.MemWriteE & live;
  assign bus.PCSrcGE    = bus.PCSrcE & live;
  assign bus.Flags      = flags_q;
  assign bus.CarryFlag  = flags_q[FLAG_C];
  assign bus.SavedFlags = saved_q;

  // Restore beats a fired flag write; save always captures the pre-update value.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= RESET_FLAGS;
      saved_q <= RESET_FLAGS;
    end else begin
      if (bus.FlagSave)
        saved_q <= flags_q;
      if (bus.FlagRestore) begin
        flags_q <= saved_q;
      end else if (fire && cond_pass) begin
        if (bus.FlagWriteE[1]) begin
          flags_q[FLAG_N] <= bus.ALUFlags[FLAG_N];
          flags_q[FLAG_Z] <= bus.ALUFlags[FLAG_Z];
        end
        if (bus.FlagWriteE[0]) begin
          flags_q[FLAG_C] <= bus.ALUFlags[FLAG_C];
          flags_q[FLAG_V] <= bus.ALUFlags[FLAG_V];
        end
      end
    end
  end

`ifdef COND_PERF_CNT_EN
  logic [PERF_W-1:0] exec_cnt_q;
  logic [PERF_W-1:0] annul_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      exec_cnt_q  <= '0;
      annul_cnt_q <= '0;
    end else if (fire) begin
      if (cond_pass)
        exec_cnt_q  <= exec_cnt_q + 1'b1;
      else
        annul_cnt_q <= annul_cnt_q + 1'b1;
    end
  end

  assign bus.ExecCount  = exec_cnt_q;
  assign bus.AnnulCount = annul_cnt_q;
`endif

endmodule
